// File: rtl/systemizer_sched.sv
// systemizer_sched: top-level sequencer around the single-pass GF(2) systemizer.
// Requests a matrix fill, starts the systemizer, and on a singular-matrix fail
// re-requests a fill and retries, up to MAX_TRY attempts. It also owns the
// systemizer memory port: loader writes pass only in LOAD, consumer reads pass
// only in READY.
// Optional feature: define SYS_WATCHDOG_EN to build a RUN watchdog that treats
// a pass lasting TIMEOUT cycles as a failed pass.
module systemizer_sched #(
  parameter int N       = 20,
  parameter int L       = 200,
  parameter int K       = 400,
  parameter int MAX_TRY = 16,
  parameter int TIMEOUT = 2**20,
  localparam int AW     = $clog2(L * K / N),
  localparam int TW     = $clog2(MAX_TRY + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_start,
  input  logic          i_release,
  output logic          o_load_req,
  input  logic          i_load_done,
  input  logic          i_ld_wr_en,
  input  logic [AW-1:0] i_ld_wr_addr,
  input  logic [N-1:0]  i_ld_data,
  output logic          o_sys_start,
  input  logic          i_sys_done,
  input  logic          i_sys_fail,
  output logic          o_sys_wr_en,
  output logic [AW-1:0] o_sys_wr_addr,
  output logic [N-1:0]  o_sys_data_in,
  input  logic          i_cons_rd_en,
  input  logic [AW-1:0] i_cons_rd_addr,
  output logic          o_sys_rd_en,
  output logic [AW-1:0] o_sys_rd_addr,
  output logic          o_busy,
  output logic          o_ok,
  output logic          o_err,
  output logic [TW-1:0] o_try_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READY,
    S_ERROR
  } state_t;

  localparam logic [TW-1:0] MAX_TRY_W = TW'(MAX_TRY);
  localparam logic [TW-1:0] ONE_W     = TW'(1);

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_try_cnt, w_try_next;
  logic          r_load_req, w_load_req_next;
  logic          r_sys_start, w_sys_start_next;
  logic          r_busy, r_ok, r_err;
  logic          w_pass_ok, w_pass_fail, w_timeout;

`ifdef SYS_WATCHDOG_EN
  localparam int            WW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] r_wd_cnt;

  // Count RUN cycles; held at zero outside RUN so each pass starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != S_RUN) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != WD_LAST) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RUN) && (r_wd_cnt == WD_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // A real sys_done always wins over a watchdog expiry in the same cycle.
  assign w_pass_ok   = i_sys_done && !i_sys_fail;
  assign w_pass_fail = (i_sys_done && i_sys_fail) || (w_timeout && !i_sys_done);

  // Next-state, attempt counter and pulse decode for the request sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_state_next     = r_state;
    w_try_next       = r_try_cnt;
    w_load_req_next  = 1'b0;
    w_sys_start_next = 1'b0;
    case (r_state)
      S_IDLE, S_READY, S_ERROR: begin
        if (i_req_start) begin
          w_state_next    = S_LOAD;
          w_try_next      = ONE_W;
          w_load_req_next = 1'b1;
        end else if (r_state == S_READY && i_release) begin
          w_state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (i_load_done) begin
          w_state_next     = S_RUN;
          w_sys_start_next = 1'b1;
        end
      end
      S_RUN: begin
        if (w_pass_ok) begin
          w_state_next = S_READY;
        end else if (w_pass_fail) begin
          if (r_try_cnt < MAX_TRY_W) begin
            w_state_next    = S_LOAD;
            w_try_next      = r_try_cnt + 1'b1;
            w_load_req_next = 1'b1;
          end else begin
            w_state_next = S_ERROR;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counter and registered outputs; status flags track the next state
  // so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_try_cnt   <= '0;
      r_load_req  <= 1'b0;
      r_sys_start <= 1'b0;
      r_busy      <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_try_cnt   <= w_try_next;
      r_load_req  <= w_load_req_next;
      r_sys_start <= w_sys_start_next;
      r_busy      <= (w_state_next == S_LOAD) || (w_state_next == S_RUN);
      r_ok        <= (w_state_next == S_READY);
      r_err       <= (w_state_next == S_ERROR);
    end
  end

  assign o_load_req  = r_load_req;
  assign o_sys_start = r_sys_start;
  assign o_busy      = r_busy;
  assign o_ok        = r_ok;
  assign o_err       = r_err;
  assign o_try_cnt   = r_try_cnt;

  // Memory port arbitration: strobes gated by state, address/data pass through.
  assign o_sys_wr_en   = i_ld_wr_en && (r_state == S_LOAD);
  assign o_sys_wr_addr = i_ld_wr_addr;
  assign o_sys_data_in = i_ld_data;
  assign o_sys_rd_en   = i_cons_rd_en && (r_state == S_READY);
  assign o_sys_rd_addr = i_cons_rd_addr;

endmodule

// File: tb/tb_systemizer_sched.sv
// Self-checking bench for systemizer_sched: a cycle table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_systemizer_sched;

  localparam int N   = 20;
  localparam int L   = 200;
  localparam int K   = 400;
  localparam int MT  = 3;
  localparam int TO  = 64;
  localparam int AW  = $clog2(L * K / N);
  localparam int TW  = $clog2(MT + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_start = 1'b0, rel = 1'b0, load_done = 1'b0;
  logic          sys_done = 1'b0, sys_fail = 1'b0;
  logic          ld_wr_en = 1'b0, cons_rd_en = 1'b0;
  logic [AW-1:0] ld_wr_addr = '0, cons_rd_addr = '0;
  logic [N-1:0]  ld_data = '0;
  logic          load_req, sys_start, sys_wr_en, sys_rd_en, busy, ok, err;
  logic [AW-1:0] sys_wr_addr, sys_rd_addr;
  logic [N-1:0]  sys_data_in;
  logic [TW-1:0] try_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int n_lr     = 0;
  int n_ss     = 0;

  always #5 clk = ~clk;

  systemizer_sched #(.N(N), .L(L), .K(K), .MAX_TRY(MT), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_start(req_start), .i_release(rel),
    .o_load_req(load_req), .i_load_done(load_done),
    .i_ld_wr_en(ld_wr_en), .i_ld_wr_addr(ld_wr_addr), .i_ld_data(ld_data),
    .o_sys_start(sys_start), .i_sys_done(sys_done), .i_sys_fail(sys_fail),
    .o_sys_wr_en(sys_wr_en), .o_sys_wr_addr(sys_wr_addr), .o_sys_data_in(sys_data_in),
    .i_cons_rd_en(cons_rd_en), .i_cons_rd_addr(cons_rd_addr),
    .o_sys_rd_en(sys_rd_en), .o_sys_rd_addr(sys_rd_addr),
    .o_busy(busy), .o_ok(ok), .o_err(err), .o_try_cnt(try_cnt)
  );

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (load_req)  n_lr++;
    if (sys_start) n_ss++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; req_start = 1'b0; rel = 1'b0; load_done = 1'b0;
    sys_done = 1'b0; sys_fail = 1'b0; ld_wr_en = 1'b0; cons_rd_en = 1'b0;
  endtask

  task automatic check_regs(input string nm, input logic lr, input logic ss, input logic b,
                            input logic o, input logic e, input logic [TW-1:0] t);
    check({nm, ".load_req"}, load_req, lr);
    check({nm, ".sys_start"}, sys_start, ss);
    check({nm, ".busy"}, busy, b);
    check({nm, ".ok"}, ok, o);
    check({nm, ".err"}, err, e);
    check({nm, ".try_cnt"}, try_cnt, t);
  endtask

  // Drive both strobes with fresh address/data and check gating plus pass-through.
  task automatic gate_check(input string nm, input logic exp_wr, input logic exp_rd);
    ld_wr_en = 1'b1; cons_rd_en = 1'b1;
    ld_wr_addr = AW'($urandom); ld_data = N'($urandom); cons_rd_addr = AW'($urandom);
    #1;
    check({nm, ".sys_wr_en"}, sys_wr_en, exp_wr);
    check({nm, ".sys_rd_en"}, sys_rd_en, exp_rd);
    check({nm, ".wr_addr"}, sys_wr_addr, ld_wr_addr);
    check({nm, ".data"}, sys_data_in, ld_data);
    check({nm, ".rd_addr"}, sys_rd_addr, cons_rd_addr);
    ld_wr_en = 1'b0; cons_rd_en = 1'b0;
  endtask

  typedef struct {
    logic rst, req, rel, ldone, sdone, sfail;
    logic lr, ss, busy, ok, err;
    logic [TW-1:0] tc;
  } vec_t;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_READY = 3, M_ERR = 4;

  initial begin
    vec_t tbl[20];
    int lr0, ss0;
    int m_st, m_try, m_run;
    logic m_lr, m_ss;

    // Cycle table: inputs applied for one edge, registered outputs checked after it.
    tbl[0]  = '{1,0,0,0,0,0, 0,0,0,0,0, 0};  // reset state
    tbl[1]  = '{0,1,0,0,0,0, 1,0,1,0,0, 1};  // IDLE -> LOAD
    tbl[2]  = '{0,0,0,0,0,0, 0,0,1,0,0, 1};
    tbl[3]  = '{0,0,0,0,1,0, 0,0,1,0,0, 1};  // sys_done ignored in LOAD
    tbl[4]  = '{0,0,0,1,0,0, 0,1,1,0,0, 1};  // LOAD -> RUN
    tbl[5]  = '{0,1,0,0,0,0, 0,0,1,0,0, 1};  // req_start ignored in RUN
    tbl[6]  = '{0,0,0,0,1,1, 1,0,1,0,0, 2};  // fail, retry 2
    tbl[7]  = '{0,0,0,1,0,0, 0,1,1,0,0, 2};
    tbl[8]  = '{0,0,0,0,1,1, 1,0,1,0,0, 3};  // fail, retry 3
    tbl[9]  = '{0,0,0,1,0,0, 0,1,1,0,0, 3};
    tbl[10] = '{0,0,0,0,1,1, 0,0,0,0,1, 3};  // exhausted -> ERROR
    tbl[11] = '{0,0,0,0,0,0, 0,0,0,0,1, 3};
    tbl[12] = '{0,0,0,1,0,0, 0,0,0,0,1, 3};  // load_done ignored in ERROR
    tbl[13] = '{0,1,0,0,0,0, 1,0,1,0,0, 1};  // ERROR -> LOAD
    tbl[14] = '{0,0,0,1,0,0, 0,1,1,0,0, 1};
    tbl[15] = '{0,0,0,0,1,0, 0,0,0,1,0, 1};  // success -> READY
    tbl[16] = '{0,1,1,0,0,0, 1,0,1,0,0, 1};  // req_start beats release
    tbl[17] = '{0,0,0,1,0,0, 0,1,1,0,0, 1};
    tbl[18] = '{0,0,0,0,1,0, 0,0,0,1,0, 1};
    tbl[19] = '{0,0,1,0,0,0, 0,0,0,0,0, 1};  // release -> IDLE, try_cnt holds

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; req_start = tbl[i].req; rel = tbl[i].rel;
      load_done = tbl[i].ldone; sys_done = tbl[i].sdone; sys_fail = tbl[i].sfail;
      tick();
      check_regs($sformatf("tbl%0d", i), tbl[i].lr, tbl[i].ss, tbl[i].busy,
                 tbl[i].ok, tbl[i].err, tbl[i].tc);
    end
    clear_inputs();

    // Success path with realistic latencies.
    rst = 1'b1; tick(); rst = 1'b0;
    lr0 = n_lr; ss0 = n_ss;
    req_start = 1'b1; tick(); req_start = 1'b0;
    repeat (49) tick();
    check("succ.no_early_start", n_ss - ss0, 0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    check("succ.start_after_done", sys_start, 1);
    tick();
    check("succ.start_one_cycle", sys_start, 0);
    repeat (298) tick();
    sys_done = 1'b1; tick(); sys_done = 1'b0;
    check_regs("succ", 0, 0, 0, 1, 0, 1);
    #5;
    check("succ.load_req_count", n_lr - lr0, 1);
    check("succ.sys_start_count", n_ss - ss0, 1);

    // Retry path: one fail then success, starting from READY.
    lr0 = n_lr; ss0 = n_ss;
    req_start = 1'b1; tick(); req_start = 1'b0;
    load_done = 1'b1; tick(); load_done = 1'b0;
    repeat (5) tick();
    sys_done = 1'b1; sys_fail = 1'b1; tick(); sys_done = 1'b0; sys_fail = 1'b0;
    repeat (3) tick();
    load_done = 1'b1; tick(); load_done = 1'b0;
    sys_done = 1'b1; tick(); sys_done = 1'b0;
    check_regs("retry", 0, 0, 0, 1, 0, 2);
    #5;
    check("retry.load_req_count", n_lr - lr0, 2);
    check("retry.sys_start_count", n_ss - ss0, 2);

    // Exhaust path: all attempts fail, no extra load_req afterwards.
    lr0 = n_lr;
    req_start = 1'b1; tick(); req_start = 1'b0;
    for (int a = 0; a < MT; a++) begin
      load_done = 1'b1; tick(); load_done = 1'b0;
      sys_done = 1'b1; sys_fail = 1'b1; tick(); sys_done = 1'b0; sys_fail = 1'b0;
    end
    repeat (10) tick();
    check_regs("exhaust", 0, 0, 0, 0, 1, MT);
    check("exhaust.load_req_count", n_lr - lr0, MT);

    // Gating in every state.
    rst = 1'b1; tick(); rst = 1'b0;
    gate_check("gate.idle", 0, 0);
    req_start = 1'b1; tick(); req_start = 1'b0;
    gate_check("gate.load", 1, 0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    gate_check("gate.run", 0, 0);
`ifdef SYS_WATCHDOG_EN
    // Watchdog: RUN entered at the last edge; retry fires TIMEOUT edges later.
    lr0 = n_lr;
    repeat (TO - 1) tick();
    check("wd.before.busy", busy, 1);
    check("wd.before.load_req", n_lr - lr0, 0);
    tick();
    check("wd.expire.load_req", load_req, 1);
    check("wd.expire.try_cnt", try_cnt, 2);
    load_done = 1'b1; tick(); load_done = 1'b0;
`else
    // Without the watchdog RUN waits indefinitely.
    repeat (100) tick();
    check_regs("run_wait", 0, 0, 1, 0, 0, 1);
`endif
    sys_done = 1'b1; tick(); sys_done = 1'b0;
    gate_check("gate.ready", 0, 1);

    // Reset mid-RUN aborts; a following sys_done is ignored.
    req_start = 1'b1; tick(); req_start = 1'b0;
    load_done = 1'b1; tick(); load_done = 1'b0;
    tick();
    ss0 = n_ss; lr0 = n_lr;
    rst = 1'b1; tick(); rst = 1'b0;
    check_regs("midrst", 0, 0, 0, 0, 0, 0);
    sys_done = 1'b1; tick(); sys_done = 1'b0;
    repeat (3) tick();
    check_regs("midrst.after", 0, 0, 0, 0, 0, 0);
    check("midrst.no_pulses", (n_ss - ss0) + (n_lr - lr0), 0);

    // Randomized run against a behavioural model of the request sequencer.
    m_st = M_IDLE; m_try = 0; m_lr = 0; m_ss = 0; m_run = 0;
    for (int c = 0; c < 3000; c++) begin
      rst        = (c == 0) || ($urandom_range(63) == 0);
      req_start  = ($urandom_range(9) == 0);
      rel        = ($urandom_range(5) == 0);
      load_done  = ($urandom_range(4) == 0);
      sys_done   = ($urandom_range(5) == 0);
      sys_fail   = $urandom_range(1);
      ld_wr_en   = $urandom_range(1);
      cons_rd_en = $urandom_range(1);
      ld_wr_addr = AW'($urandom); ld_data = N'($urandom); cons_rd_addr = AW'($urandom);
      #1;
      if (c > 0) begin
        check("rnd.sys_wr_en", sys_wr_en, ld_wr_en && m_st == M_LOAD);
        check("rnd.sys_rd_en", sys_rd_en, cons_rd_en && m_st == M_READY);
      end
      m_lr = 0; m_ss = 0;
      if (rst) begin
        m_st = M_IDLE; m_try = 0; m_run = 0;
      end else begin
        case (m_st)
          M_LOAD: if (load_done) begin m_st = M_RUN; m_ss = 1; m_run = 0; end
          M_RUN: begin
`ifdef SYS_WATCHDOG_EN
            if (!sys_done && m_run == TO - 1) sys_fail = 1'b1;
            if (m_run == TO - 1 || sys_done) begin
`else
            if (sys_done) begin
`endif
              if (sys_done && !sys_fail) m_st = M_READY;
              else if (m_try < MT) begin m_try++; m_st = M_LOAD; m_lr = 1; end
              else m_st = M_ERR;
            end
            m_run++;
          end
          default: begin
            if (req_start) begin m_st = M_LOAD; m_try = 1; m_lr = 1; end
            else if (m_st == M_READY && rel) m_st = M_IDLE;
          end
        endcase
      end
      tick();
      check_regs("rnd", m_lr, m_ss, m_st == M_LOAD || m_st == M_RUN,
                 m_st == M_READY, m_st == M_ERR, TW'(m_try));
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/systemizer_sched.md
Name: systemizer_sched

Overview:
- Top-level sequencer around the single-pass GF(2) systemizer.
- Requests a fresh matrix fill from the matrix generator, then starts the systemizer. On a fail (singular matrix), it re-requests a fill and retries, up to MAX_TRY attempts.
- Owns the systemizer's memory port. Loader writes are granted only while loading; consumer reads are granted only after a successful pass.

Parameters:
- N, 20: systemizer word width (bits per memory word).
- L, 200: matrix rows.
- K, 400: matrix columns.
- MAX_TRY, 16: maximum systemization attempts per request (>=1).
- TIMEOUT, 2**20: watchdog limit in cycles; used only with SYS_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_start  in  1  pulse: begin systemization request
- release  in  1  pulse: consumer finished reading the result
- load_req  out  1  one-cycle pulse to the matrix generator: refill memory
- load_done  in  1  generator finished filling memory
- ld_wr_en  in  1  loader write strobe
- ld_wr_addr  in  clog2(L*K/N)  loader write address
- ld_data  in  N  loader write data
- sys_start  out  1  one-cycle start pulse to the systemizer
- sys_done  in  1  systemizer done pulse
- sys_fail  in  1  systemizer fail flag, valid with sys_done
- sys_wr_en  out  1  gated write strobe to the systemizer
- sys_wr_addr  out  clog2(L*K/N)  write address to the systemizer
- sys_data_in  out  N  write data to the systemizer
- cons_rd_en  in  1  consumer read strobe
- cons_rd_addr  in  clog2(L*K/N)  consumer read address
- sys_rd_en  out  1  gated read strobe to the systemizer
- sys_rd_addr  out  clog2(L*K/N)  read address to the systemizer
- busy  out  1  high in LOAD or RUN
- ok  out  1  high in READY
- err  out  1  high in ERROR
- try_cnt  out  clog2(MAX_TRY+1)  attempt number of the current or last pass

Behaviour:
- Single clock clk. Synchronous active-high rst.
- On reset: state=IDLE, try_cnt=0, and every output 0.
- Reset mid-operation aborts immediately with no further pulses.
- States and transitions:
  - IDLE: req_start -> LOAD; try_cnt<=1; load_req=1 for one cycle, registered, next cycle.
  - LOAD: load_done -> RUN; sys_start=1 for exactly one cycle, the cycle after load_done is sampled.
  - RUN, sys_done && !sys_fail -> READY.
  - RUN, sys_done && sys_fail && try_cnt<MAX_TRY -> LOAD; try_cnt+1; load_req pulse.
  - RUN, sys_done && sys_fail && try_cnt==MAX_TRY -> ERROR.
  - READY: release -> IDLE. req_start (priority over release) -> LOAD with try_cnt<=1.
  - ERROR: req_start -> LOAD with try_cnt<=1. Otherwise hold.
- req_start is ignored in LOAD and RUN.
- load_done is ignored outside LOAD; sys_done/sys_fail are ignored outside RUN.
- Write path, combinational:
  - sys_wr_en = ld_wr_en && state==LOAD.
  - Address and data pass through unconditionally.
- Read path, combinational:
  - sys_rd_en = cons_rd_en && state==READY.
  - Address passes through.
- busy, ok and err are registered and decoded from state.
- try_cnt holds its value in IDLE, READY and ERROR.

Optional Feature:
- Macro SYS_WATCHDOG_EN.
- When defined:
  - A counter clears on RUN entry and increments each RUN cycle.
  - On reaching TIMEOUT-1 without sys_done, the pass is treated exactly as sys_done && sys_fail (retry or ERROR).
  - A late sys_done after leaving RUN is ignored.
- When undefined: no counter is built, and RUN waits indefinitely.

Test Plan:
- Success path: req_start; load_done 50 cycles later; sys_done=1, sys_fail=0 after 300 cycles -> exactly one load_req, one sys_start one cycle after load_done, ok=1, try_cnt=1.
- Retry path: MAX_TRY=3; first pass fails, second succeeds -> two load_req and two sys_start pulses, ok=1, try_cnt=2.
- Exhaust path: MAX_TRY=3; all three passes fail -> err=1, try_cnt=3, no fourth load_req; a later req_start -> LOAD with try_cnt=1.
- Gating: ld_wr_en in RUN and READY, cons_rd_en in LOAD, RUN and IDLE -> sys_wr_en and sys_rd_en stay 0; both pass through in their granted states.
- Reset mid-RUN: rst for 1 cycle, then sys_done -> state IDLE, all outputs 0, no sys_start. req_start+release same cycle in READY -> LOAD.
- Watchdog (SYS_WATCHDOG_EN, TIMEOUT=64, MAX_TRY=1): sys_done withheld -> err=1 exactly 64 cycles after RUN entry.
